// File: rtl/sram_fifo_pkg.sv
// sram_fifo_pkg: shared helpers for the SRAM-backed ready/valid FIFO.
//   addr_w   : SRAM address width for a given entry count
//   mcnt_w   : width of a counter that spans 0..depth
//   count_w  : width of the total-occupancy output (0..depth+2)
//   ptr_next : pointer increment with explicit wrap at depth-1, so that
//              depths that are not a power of two work
package sram_fifo_pkg;

  // Number of entries in the output queue that hides the SRAM read latency.
  localparam int OQ_DEPTH = 2;

  function automatic int addr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int mcnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int count_w(input int depth);
    return $clog2(depth + OQ_DEPTH + 1);
  endfunction

  function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/sram_fifo_outq.sv
// sram_fifo_outq: 2-entry register queue in front of the consumer.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   push, data   : write one entry (caller guarantees there is room,
//                  counting a same-cycle pop)
//   pop          : remove the head entry (only while cnt != 0)
//   head         : registered head entry
//   cnt          : number of valid entries, 0..2
// Slot contents are not reset; only cnt is, and cnt qualifies them.
module sram_fifo_outq #(
  parameter int WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       cnt
);

  logic [WIDTH-1:0] slot0;
  logic [WIDTH-1:0] slot1;

  assign head = slot0;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= 2'd0;
    end else begin
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end

  // slot0 is always the head; slot1 holds the second entry when cnt == 2.
  always_ff @(posedge clock) begin
    case ({push, pop})
      2'b10: begin
        if (cnt == 2'd0) slot0 <= data;
        else             slot1 <= data;
      end
      2'b01: slot0 <= slot1;
      2'b11: begin
        if (cnt == 2'd2) begin
          slot0 <= slot1;
          slot1 <= data;
        end else begin
          slot0 <= data;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sram_fifo_1r1w.sv
// sram_fifo_1r1w: ready/valid FIFO whose bulk storage is an external
// 1R1W SRAM with one-cycle read latency. A 2-entry output queue hides the
// read latency so the dequeue side sustains one beat per cycle. Total
// capacity is DEPTH + 2 entries.
//
// Handshake: a transfer fires on a rising clock edge where valid and ready
// are both high; valid must not depend on ready, data is held with valid
// until the transfer fires, and ready may be asserted without valid.
//
// Ports:
//   clock, reset              : sole clock, synchronous active-high reset
//   enq_valid/enq_ready/enq_bits : producer side
//   deq_valid/deq_ready/deq_bits : consumer side (valid and bits registered)
//   mem_W0_en/addr/data       : SRAM write port
//   mem_R0_en/addr            : SRAM read request
//   mem_R0_data               : SRAM read data, valid the cycle after R0_en
//   count                     : entries held (SRAM + in-flight read + queue)
//
// Optional build macro SRAM_FIFO_FLOW_EN: when the SRAM is empty and no read
// is in flight, an enqueue bypasses the SRAM straight into the output queue
// (one-cycle latency). Without it every entry passes through the SRAM.
module sram_fifo_1r1w
  import sram_fifo_pkg::*;
#(
  parameter int  DEPTH = 48,
  parameter int  WIDTH = 64,
  localparam int AW    = addr_w(DEPTH),
  localparam int CW    = count_w(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [WIDTH-1:0] enq_bits,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [WIDTH-1:0] deq_bits,
  output logic             mem_W0_en,
  output logic [AW-1:0]    mem_W0_addr,
  output logic [WIDTH-1:0] mem_W0_data,
  output logic             mem_R0_en,
  output logic [AW-1:0]    mem_R0_addr,
  input  logic [WIDTH-1:0] mem_R0_data,
  output logic [CW-1:0]    count
);

  localparam int MW = mcnt_w(DEPTH);

  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [MW-1:0]    mcnt;
  logic             inflight;
  logic [1:0]       oq_cnt;
  logic             oq_push;
  logic [WIDTH-1:0] oq_data;
  logic [2:0]       oq_load;
  logic             enq_fire;
  logic             deq_fire;
  logic             rd_issue;
  logic             wr_sram;
  logic             bypass;

  assign enq_ready = (mcnt != MW'(DEPTH));
  assign enq_fire  = enq_valid && enq_ready;
  assign deq_valid = (oq_cnt != 2'd0);
  assign deq_fire  = deq_valid && deq_ready;

  // Queue occupancy at the end of this cycle, counting the read now in
  // flight; a new read may only be issued if its data will have a slot.
  assign oq_load  = 3'(oq_cnt) + 3'(inflight) - 3'(deq_fire);
  assign rd_issue = (mcnt != '0) && (oq_load < 3'd2);

`ifdef SRAM_FIFO_FLOW_EN
  // Safe for ordering: nothing older sits in the SRAM or in flight.
  assign bypass = enq_fire && (mcnt == '0) && !inflight &&
                  ((oq_cnt != 2'd2) || deq_fire);
`else
  assign bypass = 1'b0;
`endif

  assign wr_sram = enq_fire && !bypass;

  // bypass requires !inflight, so the two push sources never coincide.
  assign oq_push = inflight || bypass;
  assign oq_data = inflight ? mem_R0_data : enq_bits;

  assign mem_W0_en   = wr_sram;
  assign mem_W0_addr = wptr;
  assign mem_W0_data = enq_bits;
  assign mem_R0_en   = rd_issue;
  assign mem_R0_addr = rptr;

  assign count = CW'(mcnt) + CW'(inflight) + CW'(oq_cnt);

  // Reset drops inflight, so read data returning after reset is ignored.
  always_ff @(posedge clock) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      mcnt     <= '0;
      inflight <= 1'b0;
    end else begin
      if (wr_sram)  wptr <= AW'(ptr_next(32'(wptr), 32'(DEPTH)));
      if (rd_issue) rptr <= AW'(ptr_next(32'(rptr), 32'(DEPTH)));
      mcnt     <= mcnt + MW'(wr_sram) - MW'(rd_issue);
      inflight <= rd_issue;
    end
  end

  sram_fifo_outq #(
    .WIDTH(WIDTH)
  ) u_outq (
    .clock (clock),
    .reset (reset),
    .push  (oq_push),
    .pop   (deq_fire),
    .data  (oq_data),
    .head  (deq_bits),
    .cnt   (oq_cnt)
  );

endmodule

// File: tb/tb_sram_fifo_1r1w.sv
// tb_sram_fifo_1r1w: directed and biased-random bench for sram_fifo_1r1w
// with a behavioural 1R1W SRAM (one-cycle read latency) attached.
module tb_sram_fifo_1r1w;

  localparam int DEPTH = 48;
  localparam int WIDTH = 64;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 3);
`ifdef SRAM_FIFO_FLOW_EN
  localparam int EXP_LAT = 1;
`else
  localparam int EXP_LAT = 3;
`endif

  logic             clock;
  logic             reset;
  logic             enq_valid;
  logic             enq_ready;
  logic [WIDTH-1:0] enq_bits;
  logic             deq_valid;
  logic             deq_ready;
  logic [WIDTH-1:0] deq_bits;
  logic             mem_W0_en;
  logic [AW-1:0]    mem_W0_addr;
  logic [WIDTH-1:0] mem_W0_data;
  logic             mem_R0_en;
  logic [AW-1:0]    mem_R0_addr;
  logic [WIDTH-1:0] mem_R0_data;
  logic [CW-1:0]    count;

  sram_fifo_1r1w dut (
    .clock       (clock),
    .reset       (reset),
    .enq_valid   (enq_valid),
    .enq_ready   (enq_ready),
    .enq_bits    (enq_bits),
    .deq_valid   (deq_valid),
    .deq_ready   (deq_ready),
    .deq_bits    (deq_bits),
    .mem_W0_en   (mem_W0_en),
    .mem_W0_addr (mem_W0_addr),
    .mem_W0_data (mem_W0_data),
    .mem_R0_en   (mem_R0_en),
    .mem_R0_addr (mem_R0_addr),
    .mem_R0_data (mem_R0_data),
    .count       (count)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [WIDTH-1:0] exp_q[$];
  bit   mon_on = 1'b0;
  int   max_count = 0;
  int   rd_viol = 0;
  int   wr_viol = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- SRAM model and occupancy tracker ----------------
  logic [WIDTH-1:0] mem_model [DEPTH];
  logic             occ [DEPTH];

  always @(posedge clock) begin
    if (mem_W0_en) mem_model[mem_W0_addr] <= mem_W0_data;
    if (mem_R0_en) mem_R0_data <= mem_model[mem_R0_addr];
  end

  // A read of an empty entry or a write over a live one is a controller bug.
  always @(negedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) occ[i] <= 1'b0;
    end else begin
      if (mem_R0_en) begin
        if (occ[mem_R0_addr] !== 1'b1) rd_viol <= rd_viol + 1;
        occ[mem_R0_addr] <= 1'b0;
      end
      if (mem_W0_en) begin
        if (occ[mem_W0_addr] !== 1'b0) wr_viol <= wr_viol + 1;
        occ[mem_W0_addr] <= 1'b1;
      end
    end
  end

  // ---------------- scoreboard monitor (random phase) ----------------
  always @(negedge clock) begin
    if (mon_on && !reset) begin
      check("rand_count", 64'(count), 64'(exp_q.size()));
      if (int'(count) > max_count) max_count = int'(count);
      if (deq_valid && deq_ready) begin
        if (exp_q.size() == 0) check("rand_underflow", 64'd1, 64'd0);
        else check("rand_data", deq_bits, exp_q.pop_front());
      end
      if (enq_valid && enq_ready) exp_q.push_back(enq_bits);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // ---------------- stimulus ----------------
  int lat;
  logic [63:0] got;
  int refused_early;
  int first_t;
  int k;
  int bubbles;
  int not_ready;
  int stale;
  int p_e;
  int p_d;

  initial begin
    reset = 1'b1;
    enq_valid = 1'b0;
    enq_bits = '0;
    deq_ready = 1'b0;
    do_reset();

    // Reset state
    check("rst_enq_ready", 64'(enq_ready), 64'd1);
    check("rst_deq_valid", 64'(deq_valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_w0_en", 64'(mem_W0_en), 64'd0);
    check("rst_r0_en", 64'(mem_R0_en), 64'd0);
    check("rst_w0_addr", 64'(mem_W0_addr), 64'd0);
    check("rst_r0_addr", 64'(mem_R0_addr), 64'd0);

    // Single beat latency
    enq_valid = 1'b1;
    enq_bits = 64'hA5;
    deq_ready = 1'b1;
    check("t1_enq_ready", 64'(enq_ready), 64'd1);
    lat = 0;
    got = '0;
    for (int c = 1; c <= 10; c++) begin
      step();
      enq_valid = 1'b0;
      if (deq_valid) begin
        lat = c;
        got = deq_bits;
        break;
      end
    end
    check("t1_latency", 64'(lat), 64'(EXP_LAT));
    check("t1_data", got, 64'hA5);
    step();
    check("t1_count_after", 64'(count), 64'd0);
    check("t1_valid_after", 64'(deq_valid), 64'd0);

    // Fill to DEPTH+2 with consumer stalled, then drain
    deq_ready = 1'b0;
    refused_early = 0;
    for (int i = 0; i < 50; i++) begin
      enq_valid = 1'b1;
      enq_bits = 64'(i);
      if (!enq_ready) refused_early++;
      step();
    end
    check("t2_all_accepted", 64'(refused_early), 64'd0);
    enq_bits = 64'd99;
    check("t2_full_ready", 64'(enq_ready), 64'd0);
    check("t2_full_count", 64'(count), 64'd50);
    step();
    check("t2_51st_refused", 64'(count), 64'd50);
    enq_valid = 1'b0;
    deq_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (i == 0) check("t2_ready_before_free", 64'(enq_ready), 64'd0);
      if (i == 1) check("t2_ready_after_free", 64'(enq_ready), 64'd1);
      check("t2_drain_valid", 64'(deq_valid), 64'd1);
      check("t2_drain_data", deq_bits, 64'(i));
      step();
    end
    check("t2_empty_count", 64'(count), 64'd0);
    check("t2_empty_valid", 64'(deq_valid), 64'd0);

    // Streaming 200 beats with the consumer always ready
    deq_ready = 1'b1;
    k = 0;
    first_t = -1;
    bubbles = 0;
    not_ready = 0;
    for (int t = 0; t < 220; t++) begin
      enq_valid = (t < 200);
      enq_bits = 64'h1000 + 64'(t);
      if (t < 200 && !enq_ready) not_ready++;
      if (deq_valid) begin
        if (first_t < 0) first_t = t;
        check("t3_data", deq_bits, 64'h1000 + 64'(k));
        k++;
      end else if (first_t >= 0 && k < 200) begin
        bubbles++;
      end
      step();
    end
    enq_valid = 1'b0;
    check("t3_first_latency", 64'(first_t), 64'(EXP_LAT));
    check("t3_beats", 64'(k), 64'd200);
    check("t3_bubbles", 64'(bubbles), 64'd0);
    check("t3_enq_stalls", 64'(not_ready), 64'd0);
    check("t3_count_end", 64'(count), 64'd0);

    // Biased random traffic against the scoreboard
    max_count = 0;
    mon_on = 1'b1;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      case ((cyc / 1000) % 3)
        0:       begin p_e = 80; p_d = 30; end
        1:       begin p_e = 40; p_d = 85; end
        default: begin p_e = 60; p_d = 60; end
      endcase
      enq_valid = ($urandom_range(0, 99) < p_e);
      enq_bits = {$urandom, $urandom};
      deq_ready = ($urandom_range(0, 99) < p_d);
      step();
    end
    enq_valid = 1'b0;
    deq_ready = 1'b1;
    repeat (60) step();
    mon_on = 1'b0;
    check("rand_drained", 64'(exp_q.size()), 64'd0);
    check("rand_max_count", 64'(max_count), 64'd50);
    check("mem_read_unwritten", 64'(rd_viol), 64'd0);
    check("mem_overwrite_live", 64'(wr_viol), 64'd0);

    // Reset while a read is in flight and 10 entries are held
    deq_ready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      enq_valid = 1'b1;
      enq_bits = 64'hDEAD_0000 + 64'(i);
      step();
    end
    enq_valid = 1'b0;
    repeat (4) step();
    check("t5_pre_count", 64'(count), 64'd11);
    deq_ready = 1'b1;
    step();
    deq_ready = 1'b0;
    check("t5_held_count", 64'(count), 64'd10);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5_rst_count", 64'(count), 64'd0);
    check("t5_rst_valid", 64'(deq_valid), 64'd0);
    check("t5_rst_ready", 64'(enq_ready), 64'd1);
    deq_ready = 1'b1;
    stale = 0;
    repeat (6) begin
      if (deq_valid) stale++;
      step();
    end
    check("t5_no_stale", 64'(stale), 64'd0);
    enq_valid = 1'b1;
    enq_bits = 64'h77;
    lat = 0;
    got = '0;
    for (int c = 1; c <= 10; c++) begin
      step();
      enq_valid = 1'b0;
      if (deq_valid) begin
        lat = c;
        got = deq_bits;
        break;
      end
    end
    check("t5_post_latency", 64'(lat), 64'(EXP_LAT));
    check("t5_post_data", got, 64'h77);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
